nibble_packer: RTL and testbench

Receive-side counterpart of the nibble shifter in the one-time-pad datapath. It accepts a stream of 4-bit nibbles, most significant nibble first, over a valid/ready handshake. It reassembles them into one `MSG_SIZE`-bit word and presents that word with a `msg_valid`/`msg_ack` handshake. It sits after the XOR/decrypt stage and rebuilds the full plaintext or ciphertext word from the per-nibble pipeline.

---
 rtl/nibble_packer.sv | 138 +++++++++++++
 tb/tb_nibble_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nibble_packer.sv
// Reassembles an MSB-first stream of 4-bit nibbles into one MSG_SIZE-bit word
// and holds it under a msg_valid/msg_ack handshake until consumed or restarted.
`ifndef MSG_SIZE
`define MSG_SIZE 16
`endif

module nibble_packer #(
  parameter int MSG_SIZE = `MSG_SIZE,
  parameter int NIBBLES  = MSG_SIZE / 4,
  parameter int CNT_W    = $clog2(NIBBLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                nib_valid,
  input  logic [3:0]          nib_in,
  output logic                nib_ready,
  output logic [MSG_SIZE-1:0] msg_out,
  output logic                msg_valid,
  input  logic                msg_ack,
  output logic [CNT_W-1:0]    nib_count
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic                  r_nibReady;
  logic                  r_msgValid;
  logic [MSG_SIZE-1:0]   r_msgOut;
  logic [CNT_W-1:0]      r_nibCount;
  // Only the first NIBBLES-1 nibbles ever need holding; the last one is
  // taken straight from nib_in when the word is loaded into msg_out.
  logic [MSG_SIZE-5:0]   r_shiftReg;

  logic                  w_accept;
  logic                  w_lastNib;
  logic [MSG_SIZE-1:0]   w_full;
  logic [MSG_SIZE-5:0]   w_shiftNext;
  logic [CNT_W-1:0]      w_countNext;
  logic                  w_loadMsg;

  assign w_accept  = nib_valid && r_nibReady;
  assign w_lastNib = (r_nibCount == CNT_W'(NIBBLES - 1));
  assign w_full    = {r_shiftReg, nib_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_nibReady <= 1'b0;
      r_msgValid <= 1'b0;
      r_msgOut   <= '0;
      r_nibCount <= '0;
      r_shiftReg <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_nibReady <= (w_stateNext == COLLECT);
      r_msgValid <= (w_stateNext == DONE);
      r_nibCount <= w_countNext;
      r_shiftReg <= w_shiftNext;
      if (w_loadMsg) begin
        r_msgOut <= w_full;
      end
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = COLLECT;
        end
      end
      COLLECT: begin
        if (!start && w_accept && w_lastNib) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_stateNext = COLLECT;
        end else if (msg_ack) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // A start in COLLECT restarts the word, but a nibble accepted on the same
  // edge still counts as the first nibble of the new word.
  always_comb begin
    w_shiftNext = r_shiftReg;
    w_countNext = r_nibCount;
    w_loadMsg   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_shiftNext = '0;
          w_countNext = '0;
        end
      end
      COLLECT: begin
        if (start) begin
          w_shiftNext = w_accept ? (MSG_SIZE-4)'(nib_in) : '0;
          w_countNext = w_accept ? CNT_W'(1) : '0;
        end else if (w_accept) begin
          w_shiftNext = w_full[MSG_SIZE-5:0];
          w_countNext = r_nibCount + CNT_W'(1);
          w_loadMsg   = w_lastNib;
        end
      end
      DONE: begin
        if (start) begin
          w_shiftNext = '0;
          w_countNext = '0;
        end else if (msg_ack) begin
          w_countNext = '0;
        end
      end
      default: begin
        w_shiftNext = '0;
        w_countNext = '0;
      end
    endcase
  end

  assign nib_ready = r_nibReady;
  assign msg_valid = r_msgValid;
  assign msg_out   = r_msgOut;
  assign nib_count = r_nibCount;

endmodule

// File: tb/tb_nibble_packer.sv
// Directed bench for nibble_packer: a 16-bit instance for handshake and
// boundary cases, plus a 64-bit instance fed by a simple nibble shifter.
module tb_nibble_packer;

  logic        clk;
  logic        rst;

  logic        start16;
  logic        nibValid16;
  logic [3:0]  nibIn16;
  logic        msgAck16;
  logic        nibReady16;
  logic [15:0] msgOut16;
  logic        msgValid16;
  logic [2:0]  nibCount16;

  logic        start64;
  logic        nibValid64;
  logic [3:0]  nibIn64;
  logic        msgAck64;
  logic        nibReady64;
  logic [63:0] msgOut64;
  logic        msgValid64;
  logic [4:0]  nibCount64;

  logic [63:0] srcShift;

  int checkCount;
  int errorCount;

  nibble_packer #(.MSG_SIZE(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .start     (start16),
    .nib_valid (nibValid16),
    .nib_in    (nibIn16),
    .nib_ready (nibReady16),
    .msg_out   (msgOut16),
    .msg_valid (msgValid16),
    .msg_ack   (msgAck16),
    .nib_count (nibCount16)
  );

  nibble_packer #(.MSG_SIZE(64)) dut64 (
    .clk       (clk),
    .rst       (rst),
    .start     (start64),
    .nib_valid (nibValid64),
    .nib_in    (nibIn64),
    .nib_ready (nibReady64),
    .msg_out   (msgOut64),
    .msg_valid (msgValid64),
    .msg_ack   (msgAck64),
    .nib_count (nibCount64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs to the 16-bit packer, then waits past the edge.
  task automatic applyStimulus(input logic st, input logic nv,
                               input logic [3:0] nib, input logic ack);
    start16    = st;
    nibValid16 = nv;
    nibIn16    = nib;
    msgAck16   = ack;
    @(posedge clk);
    #1;
    start16    = 1'b0;
    nibValid16 = 1'b0;
    nibIn16    = 4'h0;
    msgAck16   = 1'b0;
  endtask

  task automatic sendWord16(input logic [15:0] word);
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, word[i*4 +: 4], 1'b0);
    end
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1;
    start16 = 1'b0; nibValid16 = 1'b0; nibIn16 = 4'h0; msgAck16 = 1'b0;
    start64 = 1'b0; nibValid64 = 1'b0; nibIn64 = 4'h0; msgAck64 = 1'b0;
    srcShift = 64'h0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    checkOutput("reset_ready", 64'(nibReady16), 64'd0);
    checkOutput("reset_valid", 64'(msgValid16), 64'd0);
    checkOutput("reset_out",   64'(msgOut16),   64'd0);
    checkOutput("reset_count", 64'(nibCount16), 64'd0);

    applyStimulus(1'b0, 1'b1, 4'h7, 1'b0);
    checkOutput("idle_ignore_count", 64'(nibCount16), 64'd0);

    // Basic assembly
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    checkOutput("start_ready", 64'(nibReady16), 64'd1);
    applyStimulus(1'b0, 1'b1, 4'hA, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hB, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hC, 1'b0);
    checkOutput("basic_mid_count", 64'(nibCount16), 64'd3);
    checkOutput("basic_mid_valid", 64'(msgValid16), 64'd0);
    applyStimulus(1'b0, 1'b1, 4'hD, 1'b0);
    checkOutput("basic_valid", 64'(msgValid16), 64'd1);
    checkOutput("basic_out",   64'(msgOut16),   64'hABCD);
    checkOutput("basic_count", 64'(nibCount16), 64'd4);
    checkOutput("basic_ready", 64'(nibReady16), 64'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("ack_valid", 64'(msgValid16), 64'd0);
    checkOutput("ack_out",   64'(msgOut16),   64'hABCD);
    checkOutput("ack_count", 64'(nibCount16), 64'd0);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
    checkOutput("stray_ack_ready", 64'(nibReady16), 64'd0);

    // Gappy stream, then an extra nibble in DONE
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    for (int n = 1; n <= 4; n++) begin
      applyStimulus(1'b0, 1'b1, 4'(n), 1'b0);
      if (n < 4) begin
        applyStimulus(1'b0, 1'b0, 4'hE, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'hE, 1'b0);
        checkOutput("gap_count", 64'(nibCount16), 64'(n));
      end
    end
    checkOutput("gap_out",   64'(msgOut16),   64'h1234);
    checkOutput("gap_valid", 64'(msgValid16), 64'd1);
    applyStimulus(1'b0, 1'b1, 4'hF, 1'b0);
    checkOutput("overflow_out",   64'(msgOut16),   64'h1234);
    checkOutput("overflow_count", 64'(nibCount16), 64'd4);
    checkOutput("overflow_valid", 64'(msgValid16), 64'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

    // Restart mid-message with a same-cycle nibble
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h9, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h9, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'h5, 1'b0);
    checkOutput("restart_count", 64'(nibCount16), 64'd1);
    checkOutput("restart_valid", 64'(msgValid16), 64'd0);
    applyStimulus(1'b0, 1'b1, 4'h6, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h7, 1'b0);
    checkOutput("restart_no_pulse", 64'(msgValid16), 64'd0);
    applyStimulus(1'b0, 1'b1, 4'h8, 1'b0);
    checkOutput("restart_out",   64'(msgOut16),   64'h5678);
    checkOutput("restart_valid2", 64'(msgValid16), 64'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

    // Start while DONE, together with ack
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    sendWord16(16'hABCD);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    checkOutput("held_valid", 64'(msgValid16), 64'd1);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
    checkOutput("done_start_valid", 64'(msgValid16), 64'd0);
    checkOutput("done_start_ready", 64'(nibReady16), 64'd1);
    checkOutput("done_start_count", 64'(nibCount16), 64'd0);
    sendWord16(16'h0F0F);
    checkOutput("done_start_out", 64'(msgOut16), 64'h0F0F);
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);

    // Reset after two nibbles
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'h2, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b0);
    rst = 1'b0;
    checkOutput("rst_ready", 64'(nibReady16), 64'd0);
    checkOutput("rst_count", 64'(nibCount16), 64'd0);
    checkOutput("rst_out",   64'(msgOut16),   64'd0);
    checkOutput("rst_valid", 64'(msgValid16), 64'd0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
    sendWord16(16'hBEEF);
    checkOutput("beef_out",   64'(msgOut16),   64'hBEEF);
    checkOutput("beef_valid", 64'(msgValid16), 64'd1);

    // Round trip on the 64-bit instance, fed by a nibble shifter
    srcShift = 64'h0123456789ABCDEF;
    start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    checkOutput("rt_ready", 64'(nibReady64), 64'd1);
    for (int i = 0; i < 16; i++) begin
      nibValid64 = 1'b1;
      nibIn64    = srcShift[63:60];
      @(posedge clk); #1;
      srcShift = {srcShift[59:0], 4'h0};
      if (i == 14) begin
        checkOutput("rt_mid_valid", 64'(msgValid64), 64'd0);
      end
    end
    nibValid64 = 1'b0;
    nibIn64    = 4'h0;
    checkOutput("rt_valid", 64'(msgValid64), 64'd1);
    checkOutput("rt_out",   msgOut64,        64'h0123456789ABCDEF);
    checkOutput("rt_count", 64'(nibCount64), 64'd16);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
